// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter: state encoding, port ids,
// SRAM command word layout and the command packing helper.
package sram_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_LO   = S_LO,
    ST_HI   = S_HI,
    ST_TAIL = S_TAIL
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MOSI_W       = 36;
  localparam int MOSI_RW      = 35;
  localparam int MOSI_DATA_HI = 34;
  localparam int MOSI_DATA_LO = 19;
  localparam int MOSI_ADDR_HI = 18;
  localparam int MOSI_ADDR_LO = 1;
  localparam int MOSI_HALF    = 0;

  localparam logic [11:0] SRAM_WINDOW = 12'h001;

  // Build one half-word SRAM command word.
  function automatic logic [MOSI_W-1:0] pack_mosi(input logic        rw,
                                                  input logic [15:0] data,
                                                  input logic [17:0] addr,
                                                  input logic        half);
    logic [MOSI_W-1:0] w;
    w = '0;
    w[MOSI_RW]                     = rw;
    w[MOSI_DATA_HI:MOSI_DATA_LO]   = data;
    w[MOSI_ADDR_HI:MOSI_ADDR_LO]   = addr;
    w[MOSI_HALF]                   = half;
    return w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. When both ports request, the port that was
// not granted last wins; last_grant only moves when a grant is issued.
module rr_arb2
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_valid_o,
  output logic       gnt_port_o
);

  logic last_q, last_d;

  // Grant selection and next value of the last-grant pointer.
  always_comb begin
    gnt_valid_o = en_i & (req_i[PORT_I] | req_i[PORT_D]);
    gnt_port_o  = PORT_I;
    if (req_i[PORT_I] && req_i[PORT_D]) begin
      gnt_port_o = ~last_q;
    end else if (req_i[PORT_D]) begin
      gnt_port_o = PORT_D;
    end else begin
      gnt_port_o = PORT_I;
    end
    last_d = gnt_valid_o ? gnt_port_o : last_q;
  end

  // Last-grant register; after reset the I port counts as last served.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_I;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the 16-bit SRAM driver between the instruction-fetch port (I)
// and the load/store port (D). Each granted 32-bit access is issued as a
// low then high half-word command, and read data is reassembled for the
// one-cycle ack. Addresses outside the SRAM window are acked with err.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter logic [11:0] WINDOW = SRAM_WINDOW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        sram_cs_n,
  output logic [35:0] sram_mosi,
  input  logic [15:0] sram_miso,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic        rw_q, rw_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] rd_lo_q, rd_lo_d;
  logic        cs_n_q, cs_n_d;
  logic [35:0] mosi_q, mosi_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;

  logic        gnt_valid_s, gnt_port_s, arb_en_s;
  logic        sel_rw_s, sel_in_win_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic        unused_addr_bits_s;

  assign unused_addr_bits_s = ^{i_addr[1:0], d_addr[1:0], sel_addr_s[1:0]};

  // No grant while an error ack is being returned, nor outside IDLE.
  assign arb_en_s = (state_q == ST_IDLE) && !err_q;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       ({d_req, i_req}),
    .en_i        (arb_en_s),
    .gnt_valid_o (gnt_valid_s),
    .gnt_port_o  (gnt_port_s)
  );

  // Request fields of whichever port the arbiter picked this cycle.
  always_comb begin
    if (gnt_port_s == PORT_D) begin
      sel_rw_s    = d_rw;
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
    end else begin
      sel_rw_s    = 1'b0;
      sel_addr_s  = i_addr;
      sel_wdata_s = 32'd0;
    end
    sel_in_win_s = (sel_addr_s[31:20] == WINDOW);
  end

  // Sequencer next state; SRAM command and ack registers are set up one
  // cycle ahead so they appear in the LO/HI/TAIL cycles themselves.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_lo_d = rd_lo_q;
    cs_n_d  = 1'b1;
    mosi_d  = 36'd0;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          port_d  = gnt_port_s;
          rw_d    = sel_rw_s;
          addr_d  = sel_addr_s[19:2];
          wdata_d = sel_wdata_s;
          if (sel_in_win_s) begin
            state_d = ST_LO;
            cs_n_d  = 1'b0;
            mosi_d  = pack_mosi(sel_rw_s, sel_wdata_s[15:0], sel_addr_s[19:2], 1'b0);
          end else begin
            err_d   = 1'b1;
            i_ack_d = (gnt_port_s == PORT_I);
            d_ack_d = (gnt_port_s == PORT_D);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        state_d = ST_HI;
        cs_n_d  = 1'b0;
        mosi_d  = pack_mosi(rw_q, wdata_q[31:16], addr_q, 1'b1);
      end
      ST_HI: begin
        state_d = ST_TAIL;
        rd_lo_d = sram_miso;
        i_ack_d = (port_q == PORT_I);
        d_ack_d = (port_q == PORT_D);
      end
      ST_TAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and registered output updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      port_q  <= PORT_I;
      rw_q    <= 1'b0;
      addr_q  <= 18'd0;
      wdata_q <= 32'd0;
      rd_lo_q <= 16'd0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 36'd0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_lo_q <= rd_lo_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      err_q   <= err_d;
    end
  end

  // The high half only arrives from the driver in TAIL, so read data is
  // assembled combinationally in that cycle.
  always_comb begin
    i_rdata = 32'd0;
    d_rdata = 32'd0;
    if (state_q == ST_TAIL) begin
      if (port_q == PORT_I) begin
        i_rdata = {sram_miso, rd_lo_q};
      end else if (!rw_q) begin
        d_rdata = {sram_miso, rd_lo_q};
      end else begin
        d_rdata = 32'd0;
      end
    end else begin
      i_rdata = 32'd0;
    end
  end

  assign sram_cs_n = cs_n_q;
  assign sram_mosi = mosi_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_rw;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, err, sram_cs_n, busy;
  logic [31:0] i_rdata, d_rdata;
  logic [35:0] sram_mosi;
  logic [15:0] sram_miso = 16'd0;

  int passed = 0;
  int total  = 0;

  logic [15:0] mem [0:63];
  logic        mem_init = 1'b1;
  logic [31:0] ref_mem [0:31];

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .sram_cs_n(sram_cs_n), .sram_mosi(sram_mosi), .sram_miso(sram_miso),
    .busy(busy)
  );

  // Half-word SRAM driver model: read data appears one cycle after the command.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 64; j++) mem[j] <= 16'd0;
      sram_miso <= 16'd0;
    end else if (!sram_cs_n) begin
      if (sram_mosi[35]) mem[sram_mosi[5:0]] <= sram_mosi[34:19];
      sram_miso <= sram_mosi[35] ? 16'd0 : mem[sram_mosi[5:0]];
    end else begin
      sram_miso <= 16'd0;
    end
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
  endtask

  // One access from a single requester, checked cycle by cycle against the
  // word-level reference memory. Called at a negedge while the DUT is idle.
  task automatic run_single(input string tag, input logic port, input logic rw,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic        in_win, rwe;
    logic [17:0] a18;
    logic [31:0] wd, exp_rd;
    in_win = (addr[31:20] == 12'h001);
    a18    = addr[19:2];
    rwe    = port & rw;
    wd     = port ? wdata : 32'd0;
    exp_rd = (in_win && !rwe) ? ref_mem[a18[4:0]] : 32'd0;
    if (port) begin
      d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    if (in_win) begin
      @(negedge clk);
      chk({tag, ":lo_cs"}, sram_cs_n, 1'b0);
      chk({tag, ":lo_mosi"}, sram_mosi, {rwe, wd[15:0], a18, 1'b0});
      chk({tag, ":lo_acks"}, {i_ack, d_ack}, 2'b00);
      @(negedge clk);
      chk({tag, ":hi_cs"}, sram_cs_n, 1'b0);
      chk({tag, ":hi_mosi"}, sram_mosi, {rwe, wd[31:16], a18, 1'b1});
      chk({tag, ":hi_busy"}, busy, 1'b1);
      @(negedge clk);
      chk({tag, ":acks"}, {i_ack, d_ack}, port ? 2'b01 : 2'b10);
      chk({tag, ":err"}, err, 1'b0);
      chk({tag, ":rdata"}, port ? d_rdata : i_rdata, exp_rd);
      chk({tag, ":other_rdata"}, port ? i_rdata : d_rdata, 32'd0);
      chk({tag, ":tail_cs"}, {sram_cs_n, sram_mosi}, {1'b1, 36'd0});
      if (rwe) ref_mem[a18[4:0]] = wd;
    end else begin
      @(negedge clk);
      chk({tag, ":err_acks"}, {i_ack, d_ack}, port ? 2'b01 : 2'b10);
      chk({tag, ":err"}, err, 1'b1);
      chk({tag, ":err_rdata"}, {i_rdata, d_rdata}, 64'd0);
      chk({tag, ":err_cs"}, {sram_cs_n, busy}, 2'b10);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk({tag, ":after"}, {busy, i_ack, d_ack, err, sram_cs_n}, 5'b00001);
  endtask

  initial begin
    logic        p, w;
    logic [31:0] a, wd;
    logic [11:0] bad_tops [0:3];
    bad_tops[0] = 12'h000; bad_tops[1] = 12'h002;
    bad_tops[2] = 12'hFFF; bad_tops[3] = 12'h801;
    for (int j = 0; j < 32; j++) ref_mem[j] = 32'd0;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_rw = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("reset_outputs", {sram_cs_n, busy, i_ack, d_ack, err}, 5'b10000);
    chk("reset_mosi", sram_mosi, 36'd0);
    chk("reset_rdata", {i_rdata, d_rdata}, 64'd0);
    rst = 1'b0;

    // Directed write then read-back of the same word.
    run_single("d_write", 1'b1, 1'b1, 32'h0010_0008, 32'hDEAD_BEEF);
    run_single("i_read", 1'b0, 1'b0, 32'h0010_0008, 32'd0);
    run_single("d_write2", 1'b1, 1'b1, 32'h0010_0014, 32'h1234_5678);
    // Out-of-window read takes the error path.
    run_single("d_oow", 1'b1, 1'b0, 32'h0020_0000, 32'd0);

    // Both ports requesting from reset: D first, then alternating.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h0010_0014;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h0010_0008;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("both_d_ack_k%0d", k), d_ack, (k == 3 || k == 11));
      chk($sformatf("both_i_ack_k%0d", k), i_ack, (k == 7 || k == 15));
      if (k == 1) chk("both_first_mosi", sram_mosi, {1'b0, 16'd0, 18'h2, 1'b0});
      if (k == 3 || k == 11) chk($sformatf("both_d_rdata_k%0d", k), d_rdata, 32'hDEAD_BEEF);
      if (k == 7 || k == 15) chk($sformatf("both_i_rdata_k%0d", k), i_rdata, 32'h1234_5678);
      if (k == 11) d_req = 1'b0;
      if (k == 15) i_req = 1'b0;
    end
    @(negedge clk);
    chk("both_after_busy", busy, 1'b0);

    // Reset during HI aborts the access; the held request restarts.
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h0010_0008;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hi_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", {busy, sram_cs_n, d_ack, i_ack}, 4'b0100);
    chk("rst_mosi", sram_mosi, 36'd0);
    rst = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("rst_retry_ack_k%0d", k), d_ack, (k == 6));
      if (k == 4) chk("rst_retry_cs", sram_cs_n, 1'b0);
      if (k == 6) chk("rst_retry_rdata", d_rdata, 32'hDEAD_BEEF);
    end
    d_req = 1'b0;
    @(negedge clk);

    // Single requester held across acks: one access every 4 cycles.
    i_req = 1'b1; i_addr = 32'h0010_0014;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_ack_k%0d", k), i_ack, (k % 4 == 3));
      chk($sformatf("b2b_busy_k%0d", k), busy, (k % 4 != 0));
      if (k % 4 == 3) chk($sformatf("b2b_rdata_k%0d", k), i_rdata, 32'h1234_5678);
      if (k == 11) i_req = 1'b0;
    end

    // Randomized single-port traffic against the word-level model.
    for (int n = 0; n < 40; n++) begin
      p  = 1'($urandom_range(1, 0));
      w  = p & 1'($urandom_range(1, 0));
      wd = $urandom;
      if ($urandom_range(7, 0) == 0)
        a = {bad_tops[$urandom_range(3, 0)], 20'($urandom)};
      else
        a = {12'h001, 13'd0, 5'($urandom_range(31, 0)), 2'($urandom_range(3, 0))};
      run_single($sformatf("rnd%0d", n), p, w, a, wd);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
